// File: rtl/weight_buffer.sv
// ---------------------------------------------------------------------------
// weight_buffer
//
// Burst-oriented weight store for the convolution core. Holds KERNELS kernels
// of PIXELS weights each. A LOAD command fills one kernel from a valid/ready
// write stream, a STREAM command replays one kernel on a valid/ready read
// stream with backpressure, and a QUERY command returns the two configured
// dimensions as a two-beat burst.
//
// Ports
//   Clk       : clock, all state on the rising edge
//   Rst_n     : asynchronous active-low reset
//   CS        : chip select, qualifies start
//   start     : command strobe, sampled only while idle
//   cmd       : 00 nop, 01 LOAD, 10 STREAM, 11 QUERY
//   kernAddr  : target kernel, latched with the command
//   dataIn    : write data            inValid  : write data valid
//   inReady   : write data accepted   dataOut  : registered read/query data
//   outValid  : dataOut valid         outReady : downstream accepts dataOut
//   outLast   : final beat of a burst busy     : command in progress
//   done      : one-cycle completion pulse
//   err       : one-cycle rejection pulse (kernel address out of range)
// ---------------------------------------------------------------------------
module weight_buffer #(
    parameter int DATA_W  = 8,
    parameter int KERNELS = 16,
    parameter int PIXELS  = 25,
    parameter int KADDR_W = $clog2(KERNELS),
    parameter int PADDR_W = $clog2(PIXELS)
) (
    input  logic               Clk,
    input  logic               Rst_n,
    input  logic               CS,
    input  logic               start,
    input  logic [1:0]         cmd,
    input  logic [KADDR_W-1:0] kernAddr,
    input  logic [DATA_W-1:0]  dataIn,
    input  logic               inValid,
    output logic               inReady,
    output logic [DATA_W-1:0]  dataOut,
    output logic               outValid,
    input  logic               outReady,
    output logic               outLast,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam logic [1:0] CMD_LOAD   = 2'b01;
    localparam logic [1:0] CMD_STREAM = 2'b10;
    localparam logic [1:0] CMD_QUERY  = 2'b11;
    localparam int         DEPTH      = KERNELS * PIXELS;
    localparam int         MEM_AW     = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_STREAM,
        S_QUERY
    } state_t;

    state_t              r_state;
    state_t              w_nextState;
    logic [KADDR_W-1:0]  r_kern;
    logic [PADDR_W-1:0]  r_pix;
    logic                r_primed;
    logic                r_allIssued;
    logic                r_done;
    logic                r_err;
    logic [DATA_W-1:0]   r_dataOut;
    logic                r_outValid;
    logic                r_outLast;
    logic [DATA_W-1:0]   r_mem [DEPTH];

    logic                w_startCmd;
    logic                w_badAddr;
    logic                w_reject;
    logic                w_accept;
    logic                w_lastPix;
    logic                w_isRead;
    logic                w_xfer;
    logic                w_issue;
    logic                w_lastIssue;
    logic [MEM_AW-1:0]   w_memAddr;
    logic [DATA_W-1:0]   w_issueData;

    // Command decode. QUERY does not address memory, so only LOAD and STREAM
    // can be rejected for an out-of-range kernel.
    assign w_startCmd = (r_state == S_IDLE) && start && CS && (cmd != 2'b00);
    assign w_badAddr  = ({1'b0, kernAddr} >= (KADDR_W + 1)'(KERNELS));
    assign w_reject   = w_startCmd && (cmd != CMD_QUERY) && w_badAddr;

    assign w_accept   = inValid && inReady;
    assign w_lastPix  = (r_pix == PADDR_W'(PIXELS - 1));
    assign w_isRead   = (r_state == S_STREAM) || (r_state == S_QUERY);
    assign w_xfer     = r_outValid && outReady;

    // The output register refills whenever it is empty or being drained, so
    // a continuously ready consumer sees one beat per cycle. r_primed spends
    // the first cycle of a read command presenting the address.
    assign w_issue     = w_isRead && r_primed && !r_allIssued && (!r_outValid || outReady);
    assign w_lastIssue = (r_state == S_QUERY) ? (r_pix == PADDR_W'(1)) : w_lastPix;
    assign w_memAddr   = MEM_AW'(int'(r_kern) * PIXELS + int'(r_pix));

    always_comb begin
        w_issueData = r_mem[w_memAddr];
        if (r_state == S_QUERY) begin
            w_issueData = (r_pix == '0) ? DATA_W'(KERNELS) : DATA_W'(PIXELS);
        end
    end

    // State register.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: every command returns to IDLE once its final word
    // is written or its final beat is taken.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_startCmd && !w_reject) begin
                    case (cmd)
                        CMD_LOAD:   w_nextState = S_LOAD;
                        CMD_STREAM: w_nextState = S_STREAM;
                        default:    w_nextState = S_QUERY;
                    endcase
                end
            end
            S_LOAD: begin
                if (w_accept && w_lastPix) begin
                    w_nextState = S_IDLE;
                end
            end
            default: begin
                if (w_xfer && r_outLast) begin
                    w_nextState = S_IDLE;
                end
            end
        endcase
    end

    // Datapath: pixel counter, output register and status pulses. The pixel
    // counter holds at the last index; r_allIssued marks that the final beat
    // has already been placed in the output register.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_kern      <= '0;
            r_pix       <= '0;
            r_primed    <= 1'b0;
            r_allIssued <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_dataOut   <= '0;
            r_outValid  <= 1'b0;
            r_outLast   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= w_reject;
            case (r_state)
                S_IDLE: begin
                    if (w_startCmd) begin
                        r_kern      <= kernAddr;
                        r_pix       <= '0;
                        r_primed    <= 1'b0;
                        r_allIssued <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (w_accept) begin
                        if (w_lastPix) begin
                            r_done <= 1'b1;
                        end else begin
                            r_pix <= r_pix + 1'b1;
                        end
                    end
                end
                default: begin
                    r_primed <= 1'b1;
                    if (w_issue) begin
                        r_dataOut  <= w_issueData;
                        r_outValid <= 1'b1;
                        r_outLast  <= w_lastIssue;
                        if (w_lastIssue) begin
                            r_allIssued <= 1'b1;
                        end else begin
                            r_pix <= r_pix + 1'b1;
                        end
                    end else if (w_xfer) begin
                        r_dataOut  <= '0;
                        r_outValid <= 1'b0;
                        r_outLast  <= 1'b0;
                        if (r_outLast) begin
                            r_done <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    // Weight memory has no reset so that stored kernels survive Rst_n.
    always_ff @(posedge Clk) begin
        if (r_state == S_LOAD && inValid) begin
            r_mem[w_memAddr] <= dataIn;
        end
    end

    assign inReady  = (r_state == S_LOAD);
    assign busy     = (r_state != S_IDLE);
    assign done     = r_done;
    assign err      = r_err;
    assign dataOut  = r_dataOut;
    assign outValid = r_outValid;
    assign outLast  = r_outLast;

endmodule

// File: tb/tb_weight_buffer.sv
// ---------------------------------------------------------------------------
// tb_weight_buffer
//
// Three buffers with different geometries share one stimulus bus; chip
// select steers each command to one of them and the outputs of the selected
// one are muxed onto a common set of observation signals. A kernel-level
// model (plain arrays of stored words) supplies every expected beat.
//   unit 0 : DATA_W=8,  KERNELS=16, PIXELS=25
//   unit 1 : DATA_W=16, KERNELS=8,  PIXELS=9
//   unit 2 : DATA_W=8,  KERNELS=12, PIXELS=25
// ---------------------------------------------------------------------------
module tb_weight_buffer;

    typedef struct packed {
        logic [15:0] d;
        logic        last;
    } beat_t;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic [2:0]  csVec;
    logic        start;
    logic [1:0]  cmd;
    logic [3:0]  kernAddr;
    logic [15:0] dataIn;
    logic        inValid;
    logic        outReady;
    int          sel;

    logic        aInReady, aOutValid, aOutLast, aBusy, aDone, aErr;
    logic [7:0]  aDataOut;
    logic        bInReady, bOutValid, bOutLast, bBusy, bDone, bErr;
    logic [15:0] bDataOut;
    logic        cInReady, cOutValid, cOutLast, cBusy, cDone, cErr;
    logic [7:0]  cDataOut;

    logic        inReady, outValid, outLast, busy, done, err;
    logic [15:0] dataOut;

    int          checks = 0;
    int          failures = 0;
    logic [15:0] mm [3][16][25];
    beat_t       expQ[$];
    logic [15:0] gotQ[$];

    logic        prevValid = 1'b0;
    logic        prevReady = 1'b0;
    logic        prevLast = 1'b0;
    logic [15:0] prevData = '0;

    always #5 Clk = ~Clk;

    weight_buffer #(.DATA_W(8), .KERNELS(16), .PIXELS(25)) dutA (
        .Clk(Clk), .Rst_n(Rst_n), .CS(csVec[0]), .start(start), .cmd(cmd),
        .kernAddr(kernAddr), .dataIn(dataIn[7:0]), .inValid(inValid),
        .inReady(aInReady), .dataOut(aDataOut), .outValid(aOutValid),
        .outReady(outReady), .outLast(aOutLast), .busy(aBusy), .done(aDone),
        .err(aErr)
    );

    weight_buffer #(.DATA_W(16), .KERNELS(8), .PIXELS(9)) dutB (
        .Clk(Clk), .Rst_n(Rst_n), .CS(csVec[1]), .start(start), .cmd(cmd),
        .kernAddr(kernAddr[2:0]), .dataIn(dataIn), .inValid(inValid),
        .inReady(bInReady), .dataOut(bDataOut), .outValid(bOutValid),
        .outReady(outReady), .outLast(bOutLast), .busy(bBusy), .done(bDone),
        .err(bErr)
    );

    weight_buffer #(.DATA_W(8), .KERNELS(12), .PIXELS(25)) dutC (
        .Clk(Clk), .Rst_n(Rst_n), .CS(csVec[2]), .start(start), .cmd(cmd),
        .kernAddr(kernAddr), .dataIn(dataIn[7:0]), .inValid(inValid),
        .inReady(cInReady), .dataOut(cDataOut), .outValid(cOutValid),
        .outReady(outReady), .outLast(cOutLast), .busy(cBusy), .done(cDone),
        .err(cErr)
    );

    // Route the selected unit's outputs onto the shared observation signals.
    always_comb begin
        inReady = aInReady; dataOut = {8'h00, aDataOut}; outValid = aOutValid;
        outLast = aOutLast; busy = aBusy; done = aDone; err = aErr;
        if (sel == 1) begin
            inReady = bInReady; dataOut = bDataOut; outValid = bOutValid;
            outLast = bOutLast; busy = bBusy; done = bDone; err = bErr;
        end else if (sel == 2) begin
            inReady = cInReady; dataOut = {8'h00, cDataOut}; outValid = cOutValid;
            outLast = cOutLast; busy = cBusy; done = cDone; err = cErr;
        end
    end

    function automatic int kernelsOf(int s);
        return (s == 0) ? 16 : (s == 1) ? 8 : 12;
    endfunction

    function automatic int pixelsOf(int s);
        return (s == 1) ? 9 : 25;
    endfunction

    function automatic logic [15:0] maskOf(int s);
        return (s == 1) ? 16'hFFFF : 16'h00FF;
    endfunction

    task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Scoreboard: every transferred beat must be the next expected one, a
    // stalled beat must be held unchanged, and an idle unit shows no data.
    always @(negedge Clk) begin
        if (Rst_n) begin
            if (prevValid && !prevReady) begin
                checkOutput("holdValid", 32'(outValid), 32'd1);
                checkOutput("holdData", 32'(dataOut), 32'(prevData));
                checkOutput("holdLast", 32'(outLast), 32'(prevLast));
            end
            if (outValid && outReady) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedBeat", 32'(dataOut), 32'hFFFF_FFFF);
                end else begin
                    beat_t e;
                    e = expQ.pop_front();
                    checkOutput("beatData", 32'(dataOut), 32'(e.d));
                    checkOutput("beatLast", 32'(outLast), 32'(e.last));
                    gotQ.push_back(dataOut);
                end
            end
            if (!busy) begin
                checkOutput("idleOutValid", 32'(outValid), 32'd0);
                checkOutput("idleDataOut", 32'(dataOut), 32'd0);
            end
            prevValid = outValid;
            prevReady = outReady;
            prevData  = dataOut;
            prevLast  = outLast;
        end else begin
            prevValid = 1'b0;
            prevReady = 1'b0;
        end
    end

    // Issue a one-cycle command strobe to unit s (CS held low when useCs=0).
    task automatic applyStimulus(int s, logic [1:0] c, logic [3:0] k, bit useCs);
        sel      = s;
        csVec    = useCs ? (3'b001 << s) : 3'b000;
        start    = 1'b1;
        cmd      = c;
        kernAddr = k;
        tick();
        start = 1'b0;
        csVec = 3'b000;
        cmd   = 2'b00;
    endtask

    // Load kernel k of unit s. seqData gives words 1,2,3,...; abortAfter>=0
    // pulls reset after that many accepted words.
    task automatic doLoad(int s, logic [3:0] k, bit fullValid, bit seqData, int abortAfter);
        int          acc;
        int          cyc;
        logic [15:0] w;
        logic        acceptNow;
        acc = 0;
        cyc = 0;
        applyStimulus(s, 2'b01, k, 1'b1);
        checkOutput("loadBusy", 32'(busy), 32'd1);
        checkOutput("loadInReady", 32'(inReady), 32'd1);
        w = seqData ? 16'd1 : (16'($urandom) & maskOf(s));
        while (acc < pixelsOf(s) && cyc < 400) begin
            if (abortAfter >= 0 && acc == abortAfter) break;
            inValid   = fullValid ? 1'b1 : 1'($urandom_range(0, 1));
            dataIn    = w;
            acceptNow = inValid && inReady;
            tick();
            cyc++;
            if (acceptNow) begin
                mm[s][k][acc] = w;
                acc++;
                w = seqData ? 16'(acc + 1) : (16'($urandom) & maskOf(s));
            end
        end
        inValid = 1'b0;
        if (abortAfter >= 0) begin
            Rst_n = 1'b0;
            #1;
            checkOutput("abortInReady", 32'(inReady), 32'd0);
            checkOutput("abortBusy", 32'(busy), 32'd0);
            checkOutput("abortDone", 32'(done), 32'd0);
            checkOutput("abortOutValid", 32'(outValid), 32'd0);
            @(posedge Clk);
            #1;
            Rst_n = 1'b1;
            tick();
            checkOutput("abortDoneAfter", 32'(done), 32'd0);
            checkOutput("abortBusyAfter", 32'(busy), 32'd0);
        end else begin
            checkOutput("loadDone", 32'(done), 32'd1);
            checkOutput("loadBusyFall", 32'(busy), 32'd0);
            checkOutput("loadInReadyFall", 32'(inReady), 32'd0);
            if (fullValid) checkOutput("loadCycles", 32'(cyc), 32'(pixelsOf(s)));
            tick();
            checkOutput("loadDonePulse", 32'(done), 32'd0);
        end
    endtask

    // Run a STREAM or QUERY on unit s. readyMode: 0 always ready, 1 pattern
    // 1,0,0 repeating, 2 random. pokeStart fires a command strobe mid-burst.
    task automatic doRead(int s, logic [1:0] c, logic [3:0] k, int readyMode, bit pokeStart);
        int    n;
        int    i;
        beat_t b;
        expQ.delete();
        gotQ.delete();
        if (c == 2'b11) begin
            b.d = 16'(kernelsOf(s)) & maskOf(s); b.last = 1'b0; expQ.push_back(b);
            b.d = 16'(pixelsOf(s)) & maskOf(s);  b.last = 1'b1; expQ.push_back(b);
        end else begin
            for (int j = 0; j < pixelsOf(s); j++) begin
                b.d    = mm[s][k][j];
                b.last = (j == pixelsOf(s) - 1);
                expQ.push_back(b);
            end
        end
        n = expQ.size();
        outReady = 1'b0;
        applyStimulus(s, c, k, 1'b1);
        checkOutput("readBusy", 32'(busy), 32'd1);
        checkOutput("readValidN", 32'(outValid), 32'd0);
        tick();
        checkOutput("readValidN1", 32'(outValid), 32'd0);
        tick();
        checkOutput("readValidN2", 32'(outValid), 32'd1);
        i = 0;
        while (!done && i < 400) begin
            case (readyMode)
                0:       outReady = 1'b1;
                1:       outReady = (i % 3 == 0);
                default: outReady = 1'($urandom_range(0, 1));
            endcase
            if (pokeStart && i == 3) begin
                start    = 1'b1;
                csVec    = 3'b001 << s;
                cmd      = 2'b01;
                kernAddr = 4'd1;
            end
            tick();
            start = 1'b0;
            csVec = 3'b000;
            cmd   = 2'b00;
            checkOutput("readNoErr", 32'(err), 32'd0);
            i++;
        end
        checkOutput("readDone", 32'(done), 32'd1);
        checkOutput("readBusyFall", 32'(busy), 32'd0);
        checkOutput("readBeatsLeft", 32'(expQ.size()), 32'd0);
        checkOutput("readBeatCount", 32'(gotQ.size()), 32'(n));
        if (readyMode == 0) checkOutput("readCycles", 32'(i), 32'(n));
        outReady = 1'b0;
        tick();
        checkOutput("readDonePulse", 32'(done), 32'd0);
    endtask

    initial begin
        Rst_n = 1'b0; csVec = '0; start = 1'b0; cmd = 2'b00; kernAddr = '0;
        dataIn = '0; inValid = 1'b0; outReady = 1'b0; sel = 0;
        tick();
        tick();
        checkOutput("rstInReady", 32'(inReady), 32'd0);
        checkOutput("rstOutValid", 32'(outValid), 32'd0);
        checkOutput("rstOutLast", 32'(outLast), 32'd0);
        checkOutput("rstDataOut", 32'(dataOut), 32'd0);
        checkOutput("rstBusy", 32'(busy), 32'd0);
        checkOutput("rstDone", 32'(done), 32'd0);
        checkOutput("rstErr", 32'(err), 32'd0);
        Rst_n = 1'b1;
        tick();

        // Sequential words into kernel 3, replayed with full throughput.
        doLoad(0, 4'd3, 1'b1, 1'b1, -1);
        doRead(0, 2'b10, 4'd3, 0, 1'b0);
        if (gotQ.size() == 25) begin
            checkOutput("litFirst", 32'(gotQ[0]), 32'd1);
            checkOutput("litLast", 32'(gotQ[24]), 32'd25);
        end else begin
            checkOutput("litCount", 32'(gotQ.size()), 32'd25);
        end

        // Random kernel 0 with ragged valid, replayed under 1,0,0 backpressure.
        doLoad(0, 4'd0, 1'b0, 1'b0, -1);
        doRead(0, 2'b10, 4'd0, 1, 1'b0);

        // Dimension queries on two geometries.
        doRead(0, 2'b11, 4'd0, 0, 1'b0);
        checkOutput("litQueryK", 32'(gotQ.size() > 0 ? gotQ[0] : 16'hDEAD), 32'd16);
        checkOutput("litQueryP", 32'(gotQ.size() > 1 ? gotQ[1] : 16'hDEAD), 32'd25);
        doRead(1, 2'b11, 4'd0, 2, 1'b0);
        checkOutput("litQueryK2", 32'(gotQ.size() > 0 ? gotQ[0] : 16'hDEAD), 32'd8);
        checkOutput("litQueryP2", 32'(gotQ.size() > 1 ? gotQ[1] : 16'hDEAD), 32'd9);

        // Out-of-range kernel on the 12-kernel unit is rejected untouched.
        doLoad(2, 4'd0, 1'b1, 1'b0, -1);
        applyStimulus(2, 2'b01, 4'd15, 1'b1);
        checkOutput("errPulse", 32'(err), 32'd1);
        checkOutput("errBusy", 32'(busy), 32'd0);
        checkOutput("errInReady", 32'(inReady), 32'd0);
        tick();
        checkOutput("errPulseEnd", 32'(err), 32'd0);
        checkOutput("errBusyAfter", 32'(busy), 32'd0);
        doRead(2, 2'b10, 4'd0, 2, 1'b0);

        // Reset part-way through reloading kernel 5 keeps the first 10 words.
        doLoad(0, 4'd5, 1'b1, 1'b0, -1);
        doLoad(0, 4'd5, 1'b1, 1'b0, 10);
        doRead(0, 2'b10, 4'd5, 2, 1'b0);

        // Strobe without chip select, and a strobe during a stream.
        applyStimulus(0, 2'b10, 4'd2, 1'b0);
        checkOutput("noCsBusy", 32'(busy), 32'd0);
        checkOutput("noCsErr", 32'(err), 32'd0);
        doRead(0, 2'b10, 4'd3, 2, 1'b1);

        // Randomised load/stream pairs across all units.
        for (int r = 0; r < 8; r++) begin
            int          s;
            logic [3:0]  k;
            s = $urandom_range(0, 2);
            k = 4'($urandom_range(0, kernelsOf(s) - 1));
            doLoad(s, k, 1'($urandom_range(0, 1)), 1'b0, -1);
            doRead(s, 2'b10, k, $urandom_range(0, 2), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
